// File: rtl/mc_bus_pkg.sv
// Shared widths and FSM encoding for the mc bus initiator.
// Imported by the interface and the initiator core.
package mc_bus_pkg;

  localparam int MC_DATA_WIDTH = 16;
  localparam int MC_ADD_WIDTH  = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } mc_state_e;

endpackage

// File: rtl/mc_bus_initiator_if.sv
// Request/response handshake plus split-tristate memory bus.
// master = the initiator, slave = its requester and bus model.
interface mc_bus_initiator_if
  import mc_bus_pkg::*;
();

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [MC_ADD_WIDTH-1:0]  req_addr;
  logic [MC_DATA_WIDTH-1:0] req_wdata;
  logic                     rsp_valid;
  logic [MC_DATA_WIDTH-1:0] rsp_rdata;
  logic                     mc_ce;
  logic                     mc_oe;
  logic                     mc_we;
  logic [MC_ADD_WIDTH-1:0]  mc_add;
  logic [MC_DATA_WIDTH-1:0] mc_data_o;
  logic                     mc_data_oe;
  logic [MC_DATA_WIDTH-1:0] mc_data_i;

  modport master (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    input  mc_data_i,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output mc_ce,
    output mc_oe,
    output mc_we,
    output mc_add,
    output mc_data_o,
    output mc_data_oe
  );

  modport slave (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    output mc_data_i,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  mc_ce,
    input  mc_oe,
    input  mc_we,
    input  mc_add,
    input  mc_data_o,
    input  mc_data_oe
  );

endinterface

// File: rtl/mc_bus_initiator.sv
// Fixed-timing async memory bus initiator: setup, strobe, hold.
// All bus outputs are registered from the next-state decode.
module mc_bus_initiator
  import mc_bus_pkg::*;
#(
  parameter int unsigned ADDSET = 2,
  parameter int unsigned DATAST = 3,
  parameter int unsigned HOLD   = 1
) (
  input logic                clk,
  input logic                rst,
  mc_bus_initiator_if.master bus
);

  mc_state_e  state;
  mc_state_e  nxt_state;
  logic [3:0] cnt;
  logic [3:0] nxt_cnt;
  logic       wr_q;
  logic       wr_nxt;
  logic       accept;
  logic       last;
  logic       done;
  logic       rd_smp;
  logic       nxt_ce;
  logic       nxt_oe;
  logic       nxt_we;
  logic       nxt_doe;

  assign accept = (state == ST_IDLE)
                & bus.req_valid
                & bus.req_ready;
  assign last   = (cnt == 4'd1);
  assign wr_nxt = accept ? bus.req_write : wr_q;
  assign done   = (state != ST_IDLE)
                & (nxt_state == ST_IDLE);
  assign rd_smp = (state == ST_STROBE) & last & ~wr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          nxt_state = ST_SETUP;
          nxt_cnt   = 4'(ADDSET);
        end
      end
      ST_SETUP: begin
        if (last) begin
          nxt_state = ST_STROBE;
          nxt_cnt   = 4'(DATAST);
        end else begin
          nxt_cnt = cnt - 4'd1;
        end
      end
      ST_STROBE: begin
        if (!last) begin
          nxt_cnt = cnt - 4'd1;
        end else if (HOLD == 0) begin
          nxt_state = ST_IDLE;
        end else begin
          nxt_state = ST_HOLD;
          nxt_cnt   = 4'(HOLD);
        end
      end
      ST_HOLD: begin
        if (last) begin
          nxt_state = ST_IDLE;
        end else begin
          nxt_cnt = cnt - 4'd1;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  // Strobe levels for the cycle after this edge.
  always_comb begin
    nxt_ce  = 1'b1;
    nxt_oe  = 1'b1;
    nxt_we  = 1'b1;
    nxt_doe = 1'b0;
    unique case (1'b1)
      (nxt_state == ST_IDLE): begin
        nxt_ce = 1'b1;
      end
      (nxt_state == ST_STROBE): begin
        nxt_ce  = 1'b0;
        nxt_oe  = wr_nxt;
        nxt_we  = ~wr_nxt;
        nxt_doe = wr_nxt;
      end
      default: begin
        nxt_ce  = 1'b0;
        nxt_doe = wr_nxt;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q           <= 1'b0;
      bus.req_ready  <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_rdata  <= '0;
      bus.mc_ce      <= 1'b1;
      bus.mc_oe      <= 1'b1;
      bus.mc_we      <= 1'b1;
      bus.mc_data_oe <= 1'b0;
      bus.mc_add     <= '0;
      bus.mc_data_o  <= '0;
    end else begin
      bus.req_ready  <= (nxt_state == ST_IDLE);
      bus.rsp_valid  <= done;
      bus.mc_ce      <= nxt_ce;
      bus.mc_oe      <= nxt_oe;
      bus.mc_we      <= nxt_we;
      bus.mc_data_oe <= nxt_doe;
      if (accept) begin
        wr_q          <= bus.req_write;
        bus.mc_add    <= bus.req_addr;
        bus.mc_data_o <= bus.req_wdata;
      end
      if (rd_smp) begin
        bus.rsp_rdata <= bus.mc_data_i;
      end
    end
  end

endmodule

// File: tb/tb_mc_bus_initiator.sv
// Bench for mc_bus_initiator: vector table plus scoreboard
// monitor, default timing (dut0) and fast timing (dut1).
module tb_mc_bus_initiator;
  import mc_bus_pkg::*;

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [15:0] din;
    bit          keep;
    logic [15:0] exp_rdata;
    int          lat;
    int          n_ce;
    int          n_oe;
    int          n_we;
    int          n_doe;
    int          gap;
  } vec_t;

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          due;
    int          n_ce;
    int          n_oe;
    int          n_we;
    int          n_doe;
    int          gap;
  } exp_t;

  typedef struct {
    int ce;
    int oe;
    int we;
    int doe;
    int bad_add;
    int bad_dat;
    int gap;
  } acc_t;

  typedef struct {
    logic        ce;
    logic        oe;
    logic        we;
    logic        doe;
    logic        rsp;
    logic [5:0]  add;
    logic [15:0] dout;
    logic [15:0] rdata;
  } samp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  exp_t sbq[2][$];
  acc_t acc[2];
  int   ce_hi[2];
  int   rsp_seen[2];
  int   pushed[2];
  vec_t vt[6];

  mc_bus_initiator_if bi0 ();
  mc_bus_initiator_if bi1 ();

  mc_bus_initiator dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bi0.master)
  );

  mc_bus_initiator #(
    .ADDSET (1),
    .DATAST (1),
    .HOLD   (0)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bi1.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic mon_step(input int i, input samp_t s);
    exp_t e;
    if (!rst) begin
      sbq[i].delete();
      acc[i] = '{default: 0};
      ce_hi[i] = 0;
      return;
    end
    chk($sformatf("d%0d_ce_without_txn", i),
        32'(!s.ce && sbq[i].size() == 0), 0);
    chk($sformatf("d%0d_doe_while_oe", i),
        32'(s.doe && !s.oe), 0);
    chk($sformatf("d%0d_oe_we_both_low", i),
        32'(!s.oe && !s.we), 0);
    chk($sformatf("d%0d_rsp_without_txn", i),
        32'(s.rsp && sbq[i].size() == 0), 0);
    if (!s.ce && sbq[i].size() != 0) begin
      e = sbq[i][0];
      if (acc[i].ce == 0) acc[i].gap = ce_hi[i];
      acc[i].ce++;
      if (!s.oe) acc[i].oe++;
      if (!s.we) acc[i].we++;
      if (s.doe) acc[i].doe++;
      if (s.add !== e.addr) acc[i].bad_add++;
      if (s.doe && s.dout !== e.wdata) acc[i].bad_dat++;
    end
    if (s.ce) ce_hi[i]++;
    else ce_hi[i] = 0;
    if (s.rsp && sbq[i].size() != 0) begin
      e = sbq[i].pop_front();
      chk($sformatf("d%0d_rsp_cycle", i), cyc, e.due);
      chk($sformatf("d%0d_rsp_rdata", i), 32'(s.rdata), 32'(e.rdata));
      chk($sformatf("d%0d_ce_low_cycles", i), acc[i].ce, e.n_ce);
      chk($sformatf("d%0d_oe_low_cycles", i), acc[i].oe, e.n_oe);
      chk($sformatf("d%0d_we_low_cycles", i), acc[i].we, e.n_we);
      chk($sformatf("d%0d_doe_cycles", i), acc[i].doe, e.n_doe);
      chk($sformatf("d%0d_mc_add_wrong", i), acc[i].bad_add, 0);
      chk($sformatf("d%0d_mc_data_wrong", i), acc[i].bad_dat, 0);
      if (e.gap >= 0)
        chk($sformatf("d%0d_idle_gap", i), acc[i].gap, e.gap);
      rsp_seen[i]++;
      acc[i] = '{default: 0};
    end
  endtask

  always @(negedge clk) begin
    samp_t s0;
    samp_t s1;
    s0 = '{ce: bi0.mc_ce, oe: bi0.mc_oe, we: bi0.mc_we,
           doe: bi0.mc_data_oe, rsp: bi0.rsp_valid,
           add: bi0.mc_add, dout: bi0.mc_data_o,
           rdata: bi0.rsp_rdata};
    s1 = '{ce: bi1.mc_ce, oe: bi1.mc_oe, we: bi1.mc_we,
           doe: bi1.mc_data_oe, rsp: bi1.rsp_valid,
           add: bi1.mc_add, dout: bi1.mc_data_o,
           rdata: bi1.rsp_rdata};
    mon_step(0, s0);
    mon_step(1, s1);
  end

  task automatic set_req(input int idx, input logic v,
                         input logic w, input logic [5:0] a,
                         input logic [15:0] d);
    if (idx == 0) begin
      bi0.req_valid = v;
      bi0.req_write = w;
      bi0.req_addr  = a;
      bi0.req_wdata = d;
    end else begin
      bi1.req_valid = v;
      bi1.req_write = w;
      bi1.req_addr  = a;
      bi1.req_wdata = d;
    end
  endtask

  task automatic set_valid(input int idx, input logic v);
    if (idx == 0) bi0.req_valid = v;
    else bi1.req_valid = v;
  endtask

  task automatic set_din(input int idx, input logic [15:0] d);
    if (idx == 0) bi0.mc_data_i = d;
    else bi1.mc_data_i = d;
  endtask

  function automatic logic get_ready(input int idx);
    return (idx == 0) ? bi0.req_ready : bi1.req_ready;
  endfunction

  task automatic accept_push(input int idx, input vec_t v,
                             output bit ok);
    exp_t e;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (get_ready(idx)) begin
        ok = 1'b1;
        break;
      end
    end
    chk($sformatf("d%0d_accept_timeout", idx), 32'(ok), 1);
    if (ok) begin
      e = '{wr: v.wr, addr: v.addr, wdata: v.wdata,
            rdata: v.exp_rdata, due: cyc + v.lat,
            n_ce: v.n_ce, n_oe: v.n_oe, n_we: v.n_we,
            n_doe: v.n_doe, gap: v.gap};
      sbq[idx].push_back(e);
      pushed[idx]++;
    end
  endtask

  task automatic wait_rsp(input int idx);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      if (rsp_seen[idx] >= pushed[idx]) begin
        ok = 1'b1;
        break;
      end
    end
    chk($sformatf("d%0d_rsp_timeout", idx), 32'(ok), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input int idx, input vec_t v);
    bit ok;
    if (!v.wr) set_din(idx, v.din);
    set_req(idx, 1'b1, v.wr, v.addr, v.wdata);
    accept_push(idx, v, ok);
    @(posedge clk);
    #1;
    if (!v.keep) begin
      set_valid(idx, 1'b0);
      wait_rsp(idx);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ce"}, 32'(bi0.mc_ce), 1);
    chk({tag, "_oe"}, 32'(bi0.mc_oe), 1);
    chk({tag, "_we"}, 32'(bi0.mc_we), 1);
    chk({tag, "_doe"}, 32'(bi0.mc_data_oe), 0);
    chk({tag, "_add"}, 32'(bi0.mc_add), 0);
    chk({tag, "_dout"}, 32'(bi0.mc_data_o), 0);
    chk({tag, "_rdata"}, 32'(bi0.rsp_rdata), 0);
    chk({tag, "_rsp"}, 32'(bi0.rsp_valid), 0);
    chk({tag, "_ready"}, 32'(bi0.req_ready), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bit   ok;
    int   n0;

    vt[0] = '{1'b0, 6'h15, 16'h0000, 16'hBEEF, 1'b0, 16'hBEEF,
              7, 6, 3, 0, 0, -1};
    vt[1] = '{1'b1, 6'h2A, 16'h1234, 16'h0000, 1'b0, 16'hBEEF,
              7, 6, 0, 3, 6, -1};
    vt[2] = '{1'b0, 6'h3F, 16'h0000, 16'h0000, 1'b1, 16'h0000,
              7, 6, 3, 0, 0, -1};
    vt[3] = '{1'b1, 6'h00, 16'hFFFF, 16'h0000, 1'b1, 16'h0000,
              7, 6, 0, 3, 6, 1};
    vt[4] = '{1'b0, 6'h01, 16'h0000, 16'hA5A5, 1'b0, 16'hA5A5,
              7, 6, 3, 0, 0, 1};
    vt[5] = '{1'b1, 6'h20, 16'h5A5A, 16'h0000, 1'b0, 16'hA5A5,
              7, 6, 0, 3, 6, -1};

    for (int i = 0; i < 2; i++) begin
      set_req(i, 1'b0, 1'b0, 6'h00, 16'h0000);
      set_din(i, 16'h0000);
      rsp_seen[i] = 0;
      pushed[i] = 0;
      ce_hi[i] = 0;
      acc[i] = '{default: 0};
    end

    #1 rst = 1'b0;
    #2;
    chk_reset_vals("por");
    chk("por_d1_ce", 32'(bi1.mc_ce), 1);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    chk("rel_ready_before_edge", 32'(bi0.req_ready), 0);
    @(posedge clk);
    #1;
    chk("rel_ready_after_edge", 32'(bi0.req_ready), 1);
    chk("rel_d1_ready", 32'(bi1.req_ready), 1);

    for (int i = 0; i < 6; i++) do_txn(0, vt[i]);

    // Fast timing: ADDSET=1, DATAST=1, HOLD=0.
    v = '{1'b0, 6'h0A, 16'h0000, 16'h1357, 1'b0, 16'h1357,
          3, 2, 1, 0, 0, -1};
    do_txn(1, v);
    v = '{1'b1, 6'h35, 16'h2468, 16'h0000, 1'b0, 16'h1357,
          3, 2, 0, 1, 2, -1};
    do_txn(1, v);

    // Reset pulled in the middle of a write strobe.
    v = '{1'b1, 6'h11, 16'hCAFE, 16'h0000, 1'b0, 16'h0000,
          7, 6, 0, 3, 6, -1};
    set_req(0, 1'b1, v.wr, v.addr, v.wdata);
    accept_push(0, v, ok);
    @(posedge clk);
    #1;
    set_valid(0, 1'b0);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bi0.mc_we) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rst_we_strobe_seen", 32'(ok), 1);
    n0 = rsp_seen[0];
    #2 rst = 1'b0;
    #1;
    chk_reset_vals("midrst");
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    pushed[0] = rsp_seen[0];
    pushed[1] = rsp_seen[1];
    chk("midrst_ready_before_edge", 32'(bi0.req_ready), 0);
    @(posedge clk);
    #1;
    chk("midrst_ready_after_edge", 32'(bi0.req_ready), 1);
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_no_rsp", rsp_seen[0], n0);

    // Request pins wiggle while the strobe is active.
    v = '{1'b0, 6'h07, 16'h0000, 16'h0F0F, 1'b0, 16'h0F0F,
          7, 6, 3, 0, 0, -1};
    set_din(0, v.din);
    set_req(0, 1'b1, v.wr, v.addr, v.wdata);
    accept_push(0, v, ok);
    @(posedge clk);
    #1;
    set_valid(0, 1'b0);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bi0.mc_oe) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wiggle_oe_strobe_seen", 32'(ok), 1);
    @(posedge clk);
    #1 set_req(0, 1'b1, 1'b0, 6'h3F, 16'h0000);
    @(posedge clk);
    #1 set_valid(0, 1'b0);
    @(posedge clk);
    #1 set_req(0, 1'b1, 1'b1, 6'h01, 16'hFFFF);
    @(posedge clk);
    #1 set_valid(0, 1'b0);
    wait_rsp(0);
    repeat (8) @(posedge clk);
    #1;
    chk("wiggle_no_extra_txn", rsp_seen[0], pushed[0]);
    chk("wiggle_bus_idle", 32'(bi0.mc_ce), 1);
    chk("wiggle_add_kept", 32'(bi0.mc_add), 32'h07);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
